// File: rtl/frame_buf_scheduler.sv
// frame_buf_scheduler: newest-frame ring arbiter between one writer (capture DMA) and one reader
// (display DMA). The reader always takes the latest complete frame, stale frames are dropped and
// the last frame is repeated when nothing newer is ready.
// Optional feature: define FRAME_SCHED_STATS_EN to add saturating drop_count / repeat_count outputs.
module frame_buf_scheduler #(
  parameter int                    NUM_BUFS   = 4,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0F80_0000,
  parameter logic [ADDR_WIDTH-1:0] BUF_STRIDE = 32'h0040_0000
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    wr_req,
  output logic                    wr_ack,
  output logic [ADDR_WIDTH-1:0]   wr_base,
  input  logic                    wr_done,
  input  logic                    rd_req,
  output logic                    rd_ack,
  output logic [ADDR_WIDTH-1:0]   rd_base,
  input  logic                    rd_done,
  output logic [2*NUM_BUFS-1:0]   buf_state,
  output logic                    protocol_err
`ifdef FRAME_SCHED_STATS_EN
  ,
  output logic [15:0]             drop_count,
  output logic [15:0]             repeat_count
`endif
);

  localparam int IDX_W = $clog2(NUM_BUFS);

  typedef enum logic [1:0] {
    BUF_FREE    = 2'd0,
    BUF_WRITING = 2'd1,
    BUF_READY   = 2'd2,
    BUF_READING = 2'd3
  } buf_st_e;

  typedef logic [IDX_W-1:0] idx_t;

  buf_st_e               buf_q [NUM_BUFS];
  buf_st_e               buf_d [NUM_BUFS];
  logic                  wr_held_q, wr_held_d;
  logic                  rd_held_q, rd_held_d;
  idx_t                  wr_idx_q, wr_idx_d;
  idx_t                  rd_idx_q, rd_idx_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  rd_ack_q, rd_ack_d;
  logic [ADDR_WIDTH-1:0] wr_base_q, wr_base_d;
  logic [ADDR_WIDTH-1:0] rd_base_q, rd_base_d;
  logic                  err_q, err_d;
  logic                  ready_after_wr;
  logic                  free_found, ready_found;
  idx_t                  free_idx, ready_idx;
`ifdef FRAME_SCHED_STATS_EN
  logic                  drop_inc, repeat_inc;
  logic [15:0]           drop_q, repeat_q;
`endif

  // Base address of buffer idx, wrapping modulo 2^ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] buf_addr(input idx_t idx);
    logic [ADDR_WIDTH-1:0] off;
    off = ADDR_WIDTH'(idx) * BUF_STRIDE;
    return BASE_ADDR + off;
  endfunction

  // Next state: apply wr_done, then rd_done, then both grants on the post-done buffer states.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    buf_d          = buf_q;
    wr_held_d      = wr_held_q;
    rd_held_d      = rd_held_q;
    wr_idx_d       = wr_idx_q;
    rd_idx_d       = rd_idx_q;
    wr_ack_d       = 1'b0;
    rd_ack_d       = 1'b0;
    wr_base_d      = wr_base_q;
    rd_base_d      = rd_base_q;
    err_d          = err_q;
    ready_after_wr = 1'b0;
    free_found     = 1'b0;
    ready_found    = 1'b0;
    free_idx       = '0;
    ready_idx      = '0;
`ifdef FRAME_SCHED_STATS_EN
    drop_inc       = 1'b0;
    repeat_inc     = 1'b0;
`endif

    // Completed frame becomes the newest READY one; an unread older frame is dropped.
    if (wr_done) begin
      if (wr_held_q) begin
        for (int i = 0; i < NUM_BUFS; i++) begin
          if (buf_d[i] == BUF_READY) begin
            buf_d[i] = BUF_FREE;
`ifdef FRAME_SCHED_STATS_EN
            drop_inc = 1'b1;
`endif
          end
        end
        buf_d[wr_idx_q] = BUF_READY;
        wr_held_d       = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end

    // Reader release: free the buffer if a newer frame waits, otherwise keep it for a repeat.
    if (rd_done) begin
      if (rd_held_q) begin
        for (int i = 0; i < NUM_BUFS; i++) begin
          if (buf_d[i] == BUF_READY) ready_after_wr = 1'b1;
        end
        if (ready_after_wr) begin
          buf_d[rd_idx_q] = BUF_FREE;
        end else begin
          buf_d[rd_idx_q] = BUF_READY;
`ifdef FRAME_SCHED_STATS_EN
          repeat_inc      = 1'b1;
`endif
        end
        rd_held_d = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end

    // Descending scan leaves the lowest-index FREE buffer selected.
    for (int i = NUM_BUFS - 1; i >= 0; i--) begin
      if (buf_d[i] == BUF_FREE) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (buf_d[i] == BUF_READY) begin
        ready_found = 1'b1;
        ready_idx   = IDX_W'(i);
      end
    end

    // A request still visible during its own ack cycle is the tail of the granted request.
    if (wr_req && !wr_held_d) begin
      if (free_found) begin
        buf_d[free_idx] = BUF_WRITING;
        wr_held_d       = 1'b1;
        wr_idx_d        = free_idx;
        wr_ack_d        = 1'b1;
        wr_base_d       = buf_addr(free_idx);
      end
    end else if (wr_req && !wr_ack_q) begin
      err_d = 1'b1;
    end

    if (rd_req && !rd_held_d) begin
      if (ready_found) begin
        buf_d[ready_idx] = BUF_READING;
        rd_held_d        = 1'b1;
        rd_idx_d         = ready_idx;
        rd_ack_d         = 1'b1;
        rd_base_d        = buf_addr(ready_idx);
      end
    end else if (rd_req && !rd_ack_q) begin
      err_d = 1'b1;
    end
  end

  // State and registered outputs; asynchronous reset abandons any in-flight frames.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      // NOTE: the buffer state array is small control state, so every entry is reset explicitly.
      for (int i = 0; i < NUM_BUFS; i++) buf_q[i] <= BUF_FREE;
      wr_held_q <= 1'b0;
      rd_held_q <= 1'b0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      wr_ack_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
      wr_base_q <= BASE_ADDR;
      rd_base_q <= BASE_ADDR;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together from pre-edge values.
      buf_q     <= buf_d;
      wr_held_q <= wr_held_d;
      rd_held_q <= rd_held_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      wr_ack_q  <= wr_ack_d;
      rd_ack_q  <= rd_ack_d;
      wr_base_q <= wr_base_d;
      rd_base_q <= rd_base_d;
      err_q     <= err_d;
    end
  end

`ifdef FRAME_SCHED_STATS_EN
  // Saturating statistics counters.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      drop_q   <= '0;
      repeat_q <= '0;
    end else begin
      if (drop_inc && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      if (repeat_inc && repeat_q != 16'hFFFF) repeat_q <= repeat_q + 16'd1;
    end
  end

  assign drop_count   = drop_q;
  assign repeat_count = repeat_q;
`endif

  // Pack per-buffer states, buffer i in bits [2i+1:2i].
  always_comb begin
    buf_state = '0;
    for (int i = 0; i < NUM_BUFS; i++) buf_state[2*i +: 2] = buf_q[i];
  end

  assign wr_ack       = wr_ack_q;
  assign rd_ack       = rd_ack_q;
  assign wr_base      = wr_base_q;
  assign rd_base      = rd_base_q;
  assign protocol_err = err_q;

endmodule

// File: tb/tb_frame_buf_scheduler.sv
// Testbench for frame_buf_scheduler: directed scenarios plus randomized traffic against a
// slot-based reference model (which buffer is being written, is ready, is being read).
// Honours FRAME_SCHED_STATS_EN for the optional counters.
module tb_frame_buf_scheduler;

  localparam int          NB     = 4;
  localparam logic [31:0] BASE   = 32'h0F80_0000;
  localparam logic [31:0] STRIDE = 32'h0040_0000;

  logic        sys_clk, sys_rst;
  logic        wr_req, wr_done, rd_req, rd_done;
  logic        wr_ack, rd_ack, protocol_err;
  logic [31:0] wr_base, rd_base;
  logic [7:0]  buf_state;
`ifdef FRAME_SCHED_STATS_EN
  logic [15:0] drop_count, repeat_count;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: buffer index held in each role, -1 when empty.
  int          m_wr, m_rd, m_ready;
  int          m_drop, m_rep;
  logic        m_err, m_wr_ack, m_rd_ack;
  logic [31:0] m_wr_base, m_rd_base;

  frame_buf_scheduler #(
    .NUM_BUFS(NB), .ADDR_WIDTH(32), .BASE_ADDR(BASE), .BUF_STRIDE(STRIDE)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .wr_req(wr_req), .wr_ack(wr_ack), .wr_base(wr_base), .wr_done(wr_done),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_base(rd_base), .rd_done(rd_done),
    .buf_state(buf_state), .protocol_err(protocol_err)
`ifdef FRAME_SCHED_STATS_EN
    , .drop_count(drop_count), .repeat_count(repeat_count)
`endif
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic logic [31:0] addr_of(input int i);
    return BASE + 32'(i) * STRIDE;
  endfunction

  function automatic logic [7:0] model_state();
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < NB; i++) begin
      if (i == m_wr)         s[2*i +: 2] = 2'd1;
      else if (i == m_ready) s[2*i +: 2] = 2'd2;
      else if (i == m_rd)    s[2*i +: 2] = 2'd3;
    end
    return s;
  endfunction

  task automatic model_reset();
    m_wr = -1; m_rd = -1; m_ready = -1;
    m_drop = 0; m_rep = 0; m_err = 1'b0;
    m_wr_ack = 1'b0; m_rd_ack = 1'b0;
    m_wr_base = BASE; m_rd_base = BASE;
  endtask

  // One clock of the newest-frame policy, written in terms of role slots.
  task automatic model_step(input logic wq, input logic wd, input logic rq, input logic rdn);
    logic prev_wa, prev_ra;
    int   pick;
    prev_wa = m_wr_ack; prev_ra = m_rd_ack;
    m_wr_ack = 1'b0; m_rd_ack = 1'b0;
    if (wd) begin
      if (m_wr >= 0) begin
        if (m_ready >= 0 && m_drop < 65535) m_drop++;
        m_ready = m_wr; m_wr = -1;
      end else m_err = 1'b1;
    end
    if (rdn) begin
      if (m_rd >= 0) begin
        if (m_ready < 0) begin
          m_ready = m_rd;
          if (m_rep < 65535) m_rep++;
        end
        m_rd = -1;
      end else m_err = 1'b1;
    end
    if (wq) begin
      if (m_wr < 0) begin
        pick = -1;
        for (int i = NB - 1; i >= 0; i--) if (i != m_ready && i != m_rd) pick = i;
        if (pick >= 0) begin
          m_wr = pick; m_wr_ack = 1'b1; m_wr_base = addr_of(pick);
        end
      end else if (!prev_wa) m_err = 1'b1;
    end
    if (rq) begin
      if (m_rd < 0) begin
        if (m_ready >= 0) begin
          m_rd = m_ready; m_ready = -1; m_rd_ack = 1'b1; m_rd_base = addr_of(m_rd);
        end
      end else if (!prev_ra) m_err = 1'b1;
    end
  endtask

  // Drive one cycle of inputs (called at posedge+1) and sample one time unit after the next edge.
  task automatic tick(input logic wq, input logic wd, input logic rq, input logic rdn);
    wr_req = wq; wr_done = wd; rd_req = rq; rd_done = rdn;
    @(posedge sys_clk); #1;
    wr_req = 1'b0; wr_done = 1'b0; rd_req = 1'b0; rd_done = 1'b0;
  endtask

  task automatic apply_reset();
    sys_rst = 1'b1;
    wr_req = 1'b0; wr_done = 1'b0; rd_req = 1'b0; rd_done = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++; if (wr_ack !== 1'b0) begin n_miss++; $display("FAIL rst_wr_ack: got %b want 0", wr_ack); end
    n_vec++; if (rd_ack !== 1'b0) begin n_miss++; $display("FAIL rst_rd_ack: got %b want 0", rd_ack); end
    n_vec++; if (wr_base !== BASE) begin n_miss++; $display("FAIL rst_wr_base: got %h want %h", wr_base, BASE); end
    n_vec++; if (rd_base !== BASE) begin n_miss++; $display("FAIL rst_rd_base: got %h want %h", rd_base, BASE); end
    n_vec++; if (buf_state !== 8'h00) begin n_miss++; $display("FAIL rst_state: got %h want 00", buf_state); end
    n_vec++; if (protocol_err !== 1'b0) begin n_miss++; $display("FAIL rst_err: got %b want 0", protocol_err); end
`ifdef FRAME_SCHED_STATS_EN
    n_vec++; if (drop_count !== 16'd0 || repeat_count !== 16'd0) begin
      n_miss++; $display("FAIL rst_counts: got %0d/%0d want 0/0", drop_count, repeat_count); end
`endif
  endtask

  task automatic test_newest_frame();
    apply_reset();
    // Reader with nothing ready stalls without error.
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    n_vec++; if (rd_ack !== 1'b0) begin n_miss++; $display("FAIL stall_rd_ack: got %b want 0", rd_ack); end
    // Scenario 1: first writer grant.
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++; if (wr_ack !== 1'b1) begin n_miss++; $display("FAIL s1_wr_ack: got %b want 1", wr_ack); end
    n_vec++; if (wr_base !== 32'h0F80_0000) begin n_miss++; $display("FAIL s1_wr_base: got %h want 0f800000", wr_base); end
    n_vec++; if (buf_state[1:0] !== 2'd1) begin n_miss++; $display("FAIL s1_state: got %0d want 1", buf_state[1:0]); end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (wr_ack !== 1'b0) begin n_miss++; $display("FAIL s1_ack_pulse: got %b want 0", wr_ack); end
    n_vec++; if (wr_base !== 32'h0F80_0000) begin n_miss++; $display("FAIL s1_base_hold: got %h want 0f800000", wr_base); end
    // Scenario 2.
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    n_vec++; if (buf_state !== 8'h02) begin n_miss++; $display("FAIL s2_ready: got %h want 02", buf_state); end
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    n_vec++; if (rd_ack !== 1'b1 || rd_base !== 32'h0F80_0000) begin
      n_miss++; $display("FAIL s2_rd_grant: got ack %b base %h want 1 0f800000", rd_ack, rd_base); end
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++; if (wr_ack !== 1'b1 || wr_base !== 32'h0FC0_0000) begin
      n_miss++; $display("FAIL s2_wr_grant: got ack %b base %h want 1 0fc00000", wr_ack, wr_base); end
    // Scenario 3: buf1 completes, buf2 completes and drops buf1.
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++; if (wr_base !== 32'h1000_0000) begin n_miss++; $display("FAIL s3_wr_base: got %h want 10000000", wr_base); end
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    n_vec++; if (buf_state !== 8'h23) begin n_miss++; $display("FAIL s3_drop_state: got %h want 23", buf_state); end
`ifdef FRAME_SCHED_STATS_EN
    n_vec++; if (drop_count !== 16'd1) begin n_miss++; $display("FAIL s3_drop_count: got %0d want 1", drop_count); end
`endif
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    n_vec++; if (rd_ack !== 1'b1 || rd_base !== 32'h1000_0000) begin
      n_miss++; $display("FAIL s3_rd_grant: got ack %b base %h want 1 10000000", rd_ack, rd_base); end
    n_vec++; if (buf_state !== 8'h30) begin n_miss++; $display("FAIL s3_state: got %h want 30", buf_state); end
    // Scenario 4: repeat of the same frame.
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    n_vec++; if (buf_state !== 8'h20) begin n_miss++; $display("FAIL s4_repeat_state: got %h want 20", buf_state); end
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    n_vec++; if (rd_ack !== 1'b1 || rd_base !== 32'h1000_0000) begin
      n_miss++; $display("FAIL s4_regrant: got ack %b base %h want 1 10000000", rd_ack, rd_base); end
`ifdef FRAME_SCHED_STATS_EN
    n_vec++; if (repeat_count !== 16'd1) begin n_miss++; $display("FAIL s4_repeat_count: got %0d want 1", repeat_count); end
`endif
    // Scenario 5: wr_done and rd_req together on an idle reader.
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++; if (wr_base !== 32'h0F80_0000) begin n_miss++; $display("FAIL s5_wr_base: got %h want 0f800000", wr_base); end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    n_vec++; if (buf_state !== 8'h21) begin n_miss++; $display("FAIL s5_pre_state: got %h want 21", buf_state); end
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    n_vec++; if (rd_ack !== 1'b1 || rd_base !== 32'h0F80_0000) begin
      n_miss++; $display("FAIL s5_rd_fresh: got ack %b base %h want 1 0f800000", rd_ack, rd_base); end
    n_vec++; if (buf_state !== 8'h03) begin n_miss++; $display("FAIL s5_state: got %h want 03", buf_state); end
    n_vec++; if (protocol_err !== 1'b0) begin n_miss++; $display("FAIL s5_err: got %b want 0", protocol_err); end
`ifdef FRAME_SCHED_STATS_EN
    n_vec++; if (drop_count !== 16'd2 || repeat_count !== 16'd2) begin
      n_miss++; $display("FAIL s5_counts: got %0d/%0d want 2/2", drop_count, repeat_count); end
`endif
  endtask

  task automatic test_async_reset();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++; if (buf_state !== 8'h07) begin n_miss++; $display("FAIL s6_pre_state: got %h want 07", buf_state); end
    #2 sys_rst = 1'b1;
    #1;
    n_vec++; if (buf_state !== 8'h00 || wr_ack !== 1'b0 || rd_ack !== 1'b0) begin
      n_miss++; $display("FAIL s6_async_state: got %h ack %b%b want 00 ack 00", buf_state, wr_ack, rd_ack); end
    n_vec++; if (wr_base !== BASE || rd_base !== BASE) begin
      n_miss++; $display("FAIL s6_async_base: got %h/%h want %h", wr_base, rd_base, BASE); end
    #3 sys_rst = 1'b0;
    @(posedge sys_clk); #1;
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    n_vec++; if (protocol_err !== 1'b1) begin n_miss++; $display("FAIL s6_stray_err: got %b want 1", protocol_err); end
    n_vec++; if (buf_state !== 8'h00) begin n_miss++; $display("FAIL s6_stray_state: got %h want 00", buf_state); end
  endtask

  // Random traffic; legal-only traffic when allow_bad is 0.
  task automatic test_random(input int cycles, input logic allow_bad);
    logic wq, wd, rq, rdn;
    logic [7:0] exp_state;
    apply_reset();
    model_reset();
    for (int c = 0; c < cycles; c++) begin
      wd  = (m_wr >= 0) && ($urandom_range(3) == 0);
      rdn = (m_rd >= 0) && ($urandom_range(2) == 0);
      wq  = (m_wr < 0 || wd) && ($urandom_range(2) != 0);
      rq  = (m_rd < 0 || rdn) && ($urandom_range(2) != 0);
      if (allow_bad && $urandom_range(29) == 0) wd = 1'b1;
      if (allow_bad && $urandom_range(29) == 0) rdn = 1'b1;
      if (allow_bad && $urandom_range(29) == 0) wq = 1'b1;
      if (allow_bad && $urandom_range(29) == 0) rq = 1'b1;
      model_step(wq, wd, rq, rdn);
      tick(wq, wd, rq, rdn);
      exp_state = model_state();
      n_vec++; if (wr_ack !== m_wr_ack) begin n_miss++; $display("FAIL rnd_wr_ack c%0d: got %b want %b", c, wr_ack, m_wr_ack); end
      n_vec++; if (rd_ack !== m_rd_ack) begin n_miss++; $display("FAIL rnd_rd_ack c%0d: got %b want %b", c, rd_ack, m_rd_ack); end
      n_vec++; if (wr_base !== m_wr_base) begin n_miss++; $display("FAIL rnd_wr_base c%0d: got %h want %h", c, wr_base, m_wr_base); end
      n_vec++; if (rd_base !== m_rd_base) begin n_miss++; $display("FAIL rnd_rd_base c%0d: got %h want %h", c, rd_base, m_rd_base); end
      n_vec++; if (buf_state !== exp_state) begin n_miss++; $display("FAIL rnd_state c%0d: got %h want %h", c, buf_state, exp_state); end
      n_vec++; if (protocol_err !== m_err) begin n_miss++; $display("FAIL rnd_err c%0d: got %b want %b", c, protocol_err, m_err); end
`ifdef FRAME_SCHED_STATS_EN
      n_vec++; if (drop_count !== 16'(m_drop) || repeat_count !== 16'(m_rep)) begin
        n_miss++; $display("FAIL rnd_counts c%0d: got %0d/%0d want %0d/%0d", c, drop_count, repeat_count, m_drop, m_rep); end
`endif
    end
  endtask

  initial begin
    sys_rst = 1'b1;
    wr_req = 1'b0; wr_done = 1'b0; rd_req = 1'b0; rd_done = 1'b0;
    test_reset();
    test_newest_frame();
    test_async_reset();
    test_random(3000, 1'b0);
    test_random(2000, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
